lrsc_reservation_tracker: RTL and testbench

Per-core LR/SC reservation tracker in the memory pipeline.
- Records the reservation set by a committed LR and validates each SC against it.
- Drops the reservation on timeout, probe, or flush.
- Drives the SC result back to the LSU and the per-cycle LR/SC event consumed by the difftest LR/SC event sink (coreid/valid/success).

---
 rtl/lrsc_pkg.sv | 22 ++
 rtl/lrsc_reservation_tracker.sv | 114 +++++++++++
 tb/tb_lrsc_reservation_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lrsc_pkg.sv
`default_nettype none
// lrsc_pkg -- shared state, reservation type and timing defaults for the LR/SC tracker.  Rev 1.0
package lrsc_pkg;

  localparam int unsigned LRSC_CYCLES_DEF  = 100;
  localparam int unsigned BLOCK_CYCLES_DEF = 16;

  // Reservations are kept at doubleword granularity, zero-extended from a 64-bit paddr ceiling.
  localparam int unsigned RSV_ADDR_W = 61;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_RESERVED = 1'b1
  } lrsc_state_e;

  typedef struct packed {
    logic                  valid;
    logic [RSV_ADDR_W-1:0] addr;
  } lrsc_rsv_t;

endpackage
`default_nettype wire

// File: rtl/lrsc_reservation_tracker.sv
`default_nettype none
// lrsc_reservation_tracker -- per-core LR/SC reservation, SC validation and difftest event.  Rev 1.0
module lrsc_reservation_tracker
  import lrsc_pkg::*;
#(
  parameter int unsigned PADDR_W      = 36,
  parameter int unsigned LINE_OFF     = 6,
  parameter int unsigned LRSC_CYCLES  = LRSC_CYCLES_DEF,
  parameter int unsigned BLOCK_CYCLES = BLOCK_CYCLES_DEF
) (
  input  logic               io_clock,
  input  logic               io_reset_n,
  input  logic [7:0]         io_coreid,
  input  logic               io_lr_valid,
  input  logic [PADDR_W-1:0] io_lr_paddr,
  input  logic               io_sc_valid,
  input  logic [PADDR_W-1:0] io_sc_paddr,
  input  logic               io_probe_valid,
  input  logic [PADDR_W-1:0] io_probe_paddr,
  output logic               io_probe_ready,
  input  logic               io_flush,
  output logic               io_sc_resp_valid,
  output logic               io_sc_resp_success,
  output logic [7:0]         io_evt_coreid,
  output logic               io_evt_valid,
  output logic               io_evt_success
);

  localparam int unsigned CNT_W      = $clog2(LRSC_CYCLES + 1);
  localparam int unsigned LINE_SHIFT = LINE_OFF - 3;

  lrsc_state_e      state_q, state_d;
  lrsc_rsv_t        rsv_q, rsv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_success_q;
  logic [7:0]       coreid_q;

  logic [RSV_ADDR_W-1:0] w_lr_dw;
  logic [RSV_ADDR_W-1:0] w_sc_dw;
  logic [RSV_ADDR_W-1:0] w_probe_line;
  logic [RSV_ADDR_W-1:0] w_rsv_line;
  logic [CNT_W:0]        w_cnt_inc;
  logic                  w_sc_success;
  logic                  w_probe_kill;
  logic                  w_timeout;
  logic                  w_unused;

  assign w_lr_dw      = RSV_ADDR_W'(io_lr_paddr[PADDR_W-1:3]);
  assign w_sc_dw      = RSV_ADDR_W'(io_sc_paddr[PADDR_W-1:3]);
  assign w_probe_line = RSV_ADDR_W'(io_probe_paddr[PADDR_W-1:LINE_OFF]);
  assign w_rsv_line   = rsv_q.addr >> LINE_SHIFT;

  // Sub-doubleword and sub-line offset bits never take part in matching.
  assign w_unused = ^{io_lr_paddr[2:0], io_sc_paddr[2:0], io_probe_paddr[LINE_OFF-1:0]};

  // Probes stall for the first BLOCK_CYCLES after an LR so the LR/SC pair can make progress.
  assign io_probe_ready = !((state_q == ST_RESERVED) && (cnt_q < CNT_W'(BLOCK_CYCLES)));

  assign w_sc_success = io_sc_valid && rsv_q.valid && (rsv_q.addr == w_sc_dw);
  assign w_probe_kill = io_probe_valid && io_probe_ready && rsv_q.valid &&
                        (w_rsv_line == w_probe_line);
  assign w_cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign w_timeout    = (state_q == ST_RESERVED) && (w_cnt_inc == (CNT_W + 1)'(LRSC_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    rsv_d   = rsv_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RESERVED && cnt_q != CNT_W'(LRSC_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Flush beats everything, including a same-cycle LR; any other LR wins over clears.
    if (io_flush) begin
      state_d    = ST_IDLE;
      rsv_d.valid = 1'b0;
      cnt_d      = '0;
    end else if (io_lr_valid) begin
      state_d    = ST_RESERVED;
      rsv_d.valid = 1'b1;
      rsv_d.addr = w_lr_dw;
      cnt_d      = '0;
    end else if (io_sc_valid || w_probe_kill || w_timeout) begin
      state_d    = ST_IDLE;
      rsv_d.valid = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state_q        <= ST_IDLE;
      rsv_q          <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_success_q <= 1'b0;
      coreid_q       <= 8'h00;
    end else begin
      state_q        <= state_d;
      rsv_q          <= rsv_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= io_sc_valid;
      resp_success_q <= w_sc_success;
      coreid_q       <= io_coreid;
    end
  end

  assign io_sc_resp_valid   = resp_valid_q;
  assign io_sc_resp_success = resp_success_q;
  assign io_evt_valid       = resp_valid_q;
  assign io_evt_success     = resp_success_q;
  assign io_evt_coreid      = coreid_q;

endmodule
`default_nettype wire

// File: tb/tb_lrsc_reservation_tracker.sv
`default_nettype none
// tb_lrsc_reservation_tracker -- directed self-checking bench for the LR/SC reservation tracker.  Rev 1.0
module tb_lrsc_reservation_tracker;

  localparam int unsigned PADDR_W = 36;

  logic               clk;
  logic               rst_n;
  logic [7:0]         coreid;
  logic               lr_valid;
  logic [PADDR_W-1:0] lr_paddr;
  logic               sc_valid;
  logic [PADDR_W-1:0] sc_paddr;
  logic               probe_valid;
  logic [PADDR_W-1:0] probe_paddr;
  logic               probe_ready;
  logic               flush;
  logic               resp_valid;
  logic               resp_success;
  logic [7:0]         evt_coreid;
  logic               evt_valid;
  logic               evt_success;

  int checks = 0;
  int errors = 0;

  localparam logic [PADDR_W-1:0] A  = 36'h0_8000_0040;
  localparam logic [PADDR_W-1:0] A8 = 36'h0_8000_0048;
  localparam logic [PADDR_W-1:0] B  = 36'h0_8000_2000;
  localparam logic [PADDR_W-1:0] P0 = 36'h0_8000_0000;
  localparam logic [PADDR_W-1:0] P8 = 36'h0_8000_0008;
  localparam logic [PADDR_W-1:0] PF = 36'h0_8000_1000;

  lrsc_reservation_tracker #(
    .PADDR_W(PADDR_W), .LINE_OFF(6), .LRSC_CYCLES(100), .BLOCK_CYCLES(16)
  ) dut (
    .io_clock          (clk),
    .io_reset_n        (rst_n),
    .io_coreid         (coreid),
    .io_lr_valid       (lr_valid),
    .io_lr_paddr       (lr_paddr),
    .io_sc_valid       (sc_valid),
    .io_sc_paddr       (sc_paddr),
    .io_probe_valid    (probe_valid),
    .io_probe_paddr    (probe_paddr),
    .io_probe_ready    (probe_ready),
    .io_flush          (flush),
    .io_sc_resp_valid  (resp_valid),
    .io_sc_resp_success(resp_success),
    .io_evt_coreid     (evt_coreid),
    .io_evt_valid      (evt_valid),
    .io_evt_success    (evt_success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive the request inputs, cross the edge, return 1 time unit later with them cleared.
  task automatic cyc(input logic lr, input logic [PADDR_W-1:0] la,
                     input logic sc, input logic [PADDR_W-1:0] sa, input logic fl);
    lr_valid = lr; lr_paddr = la;
    sc_valid = sc; sc_paddr = sa;
    flush    = fl;
    @(posedge clk);
    #1;
    lr_valid = 1'b0; sc_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic sc_expect(input string tag, input logic [PADDR_W-1:0] sa, input logic exp);
    cyc(1'b0, '0, 1'b1, sa, 1'b0);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_success"}, 64'(resp_success), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0; coreid = 8'h00;
    lr_valid = 1'b0; lr_paddr = '0; sc_valid = 1'b0; sc_paddr = '0;
    probe_valid = 1'b0; probe_paddr = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_success", 64'(resp_success), 64'd0);
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_evt_coreid", 64'(evt_coreid), 64'd0);
    chk("rst_probe_ready", 64'(probe_ready), 64'd1);
    rst_n = 1'b1;
    coreid = 8'h5A;

    // LR at t, SC same address at t+10
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    idle(9);
    cyc(1'b0, '0, 1'b1, A, 1'b0);
    chk("t1_resp_valid", 64'(resp_valid), 64'd1);
    chk("t1_resp_success", 64'(resp_success), 64'd1);
    chk("t1_evt_valid", 64'(evt_valid), 64'd1);
    chk("t1_evt_success", 64'(evt_success), 64'd1);
    chk("t1_evt_coreid", 64'(evt_coreid), 64'h5A);
    idle(1);
    chk("t1_pulse_end", 64'(resp_valid), 64'd0);
    chk("t1_evt_pulse_end", 64'(evt_valid), 64'd0);

    // Wrong doubleword fails and consumes the reservation
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    sc_expect("t2_wrong_dw", A8, 1'b0);
    sc_expect("t2_second_sc", A, 1'b0);

    // Probe back-pressure window, then a matching probe kills the reservation
    cyc(1'b1, P8, 1'b0, '0, 1'b0);
    probe_valid = 1'b1; probe_paddr = P0;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t3_ready_blocked_%0d", k), 64'(probe_ready), 64'd0);
      idle(1);
    end
    chk("t3_ready_open", 64'(probe_ready), 64'd1);
    idle(1);
    probe_valid = 1'b0;
    sc_expect("t3_sc_after_probe", P8, 1'b0);

    // A non-matching accepted probe leaves the reservation alone
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    idle(16);
    probe_valid = 1'b1; probe_paddr = PF;
    chk("t3b_ready", 64'(probe_ready), 64'd1);
    idle(1);
    probe_valid = 1'b0;
    sc_expect("t3b_sc_survives", A, 1'b1);

    // Lifetime boundary: SC at t+99 succeeds, t+100 fails
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    idle(98);
    sc_expect("t4_sc_at_99", A, 1'b1);
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    idle(99);
    chk("t4_ready_after_timeout", 64'(probe_ready), 64'd1);
    sc_expect("t4_sc_at_100", A, 1'b0);

    // Same-cycle SC to A with LR to B
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    cyc(1'b1, B, 1'b1, A, 1'b0);
    chk("t5_sc_old_success", 64'(resp_success), 64'd1);
    sc_expect("t5_sc_new_b", B, 1'b1);

    // Flush with SC: SC sees pre-flush state, reservation is gone afterwards
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, A, 1'b1);
    chk("t6_flush_sc_valid", 64'(resp_valid), 64'd1);
    chk("t6_flush_sc_success", 64'(resp_success), 64'd1);
    chk("t6_idle_ready", 64'(probe_ready), 64'd1);
    sc_expect("t6_after_flush", A, 1'b0);

    // Flush discards a same-cycle LR
    cyc(1'b1, A, 1'b0, '0, 1'b1);
    chk("t6b_ready", 64'(probe_ready), 64'd1);
    sc_expect("t6b_lr_discarded", A, 1'b0);

    // Asynchronous reset while RESERVED with a response showing
    cyc(1'b1, A, 1'b0, '0, 1'b0);
    cyc(1'b1, A, 1'b1, A, 1'b0);
    chk("t7_pre_valid", 64'(resp_valid), 64'd1);
    chk("t7_pre_ready", 64'(probe_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", 64'(resp_valid), 64'd0);
    chk("t7_async_success", 64'(resp_success), 64'd0);
    chk("t7_async_evt_valid", 64'(evt_valid), 64'd0);
    chk("t7_async_evt_success", 64'(evt_success), 64'd0);
    chk("t7_async_coreid", 64'(evt_coreid), 64'd0);
    chk("t7_async_ready", 64'(probe_ready), 64'd1);
    cyc(1'b0, '0, 1'b1, A, 1'b0);
    chk("t7_sc_cancelled", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    sc_expect("t7_rsv_dropped", A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
